// File: rtl/gtfwizard_mac_reset_sched.sv
// Serialises per-channel GTF reset requests so only one reset pulse is in flight at a time.
// Each grant is a fixed-width pulse followed by a hold-off gap before the next grant.
module gtfwizard_mac_reset_sched #(
    parameter int unsigned P_NUM_CH      = 4,
    parameter int unsigned P_PULSE_CYC   = 16,
    parameter int unsigned P_HOLDOFF_CYC = 1000
) (
    input  logic                clk_freerun_in,
    input  logic                reset_all_in,
    input  logic [P_NUM_CH-1:0] req_rx_in,
    input  logic [P_NUM_CH-1:0] req_all_in,
    output logic [P_NUM_CH-1:0] reset_rx_out,
    output logic                reset_all_out,
    output logic                busy_out,
    output logic [2:0]          grant_idx_out,
    output logic [7:0]          grant_cnt_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [P_NUM_CH-1:0] r_req_rx_d;
    logic [P_NUM_CH-1:0] r_req_all_d;
    logic [P_NUM_CH-1:0] r_pend_rx;
    logic [P_NUM_CH-1:0] r_pend_all;
    logic [15:0]         r_cnt;
    logic [2:0]          r_ptr;
    logic                r_mode_all;
    logic [2:0]          r_grant_idx;
    logic [7:0]          r_grant_cnt;
    logic [P_NUM_CH-1:0] r_rx_out;
    logic                r_all_out;
    logic                r_busy;

    logic [P_NUM_CH-1:0] w_edge_rx;
    logic [P_NUM_CH-1:0] w_edge_all;
    logic [P_NUM_CH-1:0] w_clr_rx;
    logic                w_clr_all;
    logic [15:0]         w_cnt_nxt;
    logic [2:0]          w_ptr_nxt;
    logic                w_mode_nxt;
    logic [2:0]          w_idx_nxt;
    logic [7:0]          w_gcnt_nxt;
    logic                w_found;
    logic [2:0]          w_pick;
    logic [2:0]          w_j;
    logic [7:0]          w_pend8;
    logic [P_NUM_CH-1:0] w_rx_nxt;

    assign w_edge_rx  = req_rx_in  & ~r_req_rx_d;
    assign w_edge_all = req_all_in & ~r_req_all_d;
    assign w_pend8    = 8'(r_pend_rx);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_rx    = '0;
        w_clr_all   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_mode_nxt  = r_mode_all;
        w_idx_nxt   = r_grant_idx;
        w_gcnt_nxt  = r_grant_cnt;
        w_found     = 1'b0;
        w_pick      = '0;
        w_j         = '0;
        // Round-robin: scan from the channel after the last RX grant, wrapping.
        for (int unsigned k = 1; k <= P_NUM_CH; k++) begin
            w_j = 3'((32'(r_ptr) + k) % P_NUM_CH);
            if (!w_found && w_pend8[w_j]) begin
                w_found = 1'b1;
                w_pick  = w_j;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (|r_pend_all) begin
                    w_state_nxt = S_PULSE;
                    w_mode_nxt  = 1'b1;
                    w_clr_all   = 1'b1;
                    w_clr_rx    = '1;
                    w_cnt_nxt   = 16'(P_PULSE_CYC - 1);
                end else if (w_found) begin
                    w_state_nxt = S_PULSE;
                    w_mode_nxt  = 1'b0;
                    w_clr_rx    = P_NUM_CH'(1) << w_pick;
                    w_ptr_nxt   = w_pick;
                    w_idx_nxt   = w_pick;
                    w_cnt_nxt   = 16'(P_PULSE_CYC - 1);
                end
                if (w_state_nxt == S_PULSE && r_grant_cnt != 8'hFF) begin
                    w_gcnt_nxt = r_grant_cnt + 8'd1;
                end
            end
            S_PULSE: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = 16'(P_HOLDOFF_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_rx_nxt = (w_state_nxt == S_PULSE && !w_mode_nxt) ? (P_NUM_CH'(1) << w_idx_nxt) : '0;
    end

    always_ff @(posedge clk_freerun_in or posedge reset_all_in) begin
        if (reset_all_in) begin
            r_state     <= S_IDLE;
            r_req_rx_d  <= '0;
            r_req_all_d <= '0;
            r_pend_rx   <= '0;
            r_pend_all  <= '0;
            r_cnt       <= '0;
            r_ptr       <= 3'(P_NUM_CH - 1);
            r_mode_all  <= 1'b0;
            r_grant_idx <= '0;
            r_grant_cnt <= '0;
            r_rx_out    <= '0;
            r_all_out   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_rx_d  <= req_rx_in;
            r_req_all_d <= req_all_in;
            // New edges win over a same-cycle grant clear.
            r_pend_rx   <= (r_pend_rx & ~w_clr_rx) | w_edge_rx;
            r_pend_all  <= (r_pend_all & ~{P_NUM_CH{w_clr_all}}) | w_edge_all;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_mode_all  <= w_mode_nxt;
            r_grant_idx <= w_idx_nxt;
            r_grant_cnt <= w_gcnt_nxt;
            r_rx_out    <= w_rx_nxt;
            r_all_out   <= (w_state_nxt == S_PULSE) && w_mode_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign reset_rx_out  = r_rx_out;
    assign reset_all_out = r_all_out;
    assign busy_out      = r_busy;
    assign grant_idx_out = r_grant_idx;
    assign grant_cnt_out = r_grant_cnt;

endmodule

// File: tb/tb_gtfwizard_mac_reset_sched.sv
// Scoreboard bench for gtfwizard_mac_reset_sched: stimulus queues expected pulses,
// a negedge monitor measures each output pulse and checks it against the queue head.
module tb_gtfwizard_mac_reset_sched;

    localparam int N = 4;
    localparam int P = 16;
    localparam int H = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_rx;
    logic [N-1:0] req_all;
    logic [N-1:0] rx_out;
    logic         all_out;
    logic         busy;
    logic [2:0]   gidx;
    logic [7:0]   gcnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int start;
        int val;
        int width;
        int idx;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    gtfwizard_mac_reset_sched #(
        .P_NUM_CH      (N),
        .P_PULSE_CYC   (P),
        .P_HOLDOFF_CYC (H)
    ) dut (
        .clk_freerun_in (clk),
        .reset_all_in   (rst),
        .req_rx_in      (req_rx),
        .req_all_in     (req_all),
        .reset_rx_out   (rx_out),
        .reset_all_out  (all_out),
        .busy_out       (busy),
        .grant_idx_out  (gidx),
        .grant_cnt_out  (gcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int s, input int v, input int w, input int i, input int c);
        exp_t e;
        e.start = s;
        e.val   = v;
        e.width = w;
        e.idx   = i;
        e.cnt   = c;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        int t;
        t = cyc;
        rst = 1'b1;
        at_cycle(t + 3);
        rst = 1'b0;
        at_cycle(t + 5);
    endtask

    // Monitor: measure each pulse on {reset_all_out, reset_rx_out} and score it when it ends.
    initial begin
        int   cur;
        int   m_prev;
        int   m_start;
        int   m_val;
        int   m_width;
        int   m_idx;
        int   m_cnt;
        exp_t e;
        m_prev = 0; m_start = 0; m_val = 0; m_width = 0; m_idx = 0; m_cnt = 0;
        forever begin
            @(negedge clk);
            cur = int'({all_out, rx_out});
            if (cur != 0 && m_prev == 0) begin
                m_start = cyc;
                m_val   = cur;
                m_width = 1;
                m_idx   = int'(gidx);
                m_cnt   = int'(gcnt);
            end else if (cur != 0) begin
                check("pulse_stable", cur, m_val);
                m_width++;
            end else if (m_prev != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=start %0d val %0d required=no pulse", m_start, m_val);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_start", m_start, e.start);
                    check("pulse_val",   m_val,   e.val);
                    check("pulse_width", m_width, e.width);
                    check("grant_idx",   m_idx,   e.idx);
                    check("grant_cnt",   m_cnt,   e.cnt);
                end
            end
            m_prev = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst     = 1'b0;
        req_rx  = '0;
        req_all = '0;
        #2 rst = 1'b1;

        // Reset state
        at_cycle(3);
        check("rst_rx_out",  int'(rx_out),  0);
        check("rst_all_out", int'(all_out), 0);
        check("rst_busy",    int'(busy),    0);
        check("rst_gidx",    int'(gidx),    0);
        check("rst_gcnt",    int'(gcnt),    0);
        rst = 1'b0;

        // 1: single ch2 request; pulse cycles t+2..t+17, busy t+2..t+27
        at_cycle(10);
        t = cyc;
        req_rx = 4'b0100;
        push_exp(t + 2, 5'b00100, P, 2, 1);
        at_cycle(t + 1);  check("busy_before", int'(busy), 0);
        at_cycle(t + 2);  check("busy_first",  int'(busy), 1);
        at_cycle(t + 27); check("busy_last",   int'(busy), 1);
        at_cycle(t + 28); check("busy_after",  int'(busy), 0);
        req_rx = '0;
        at_cycle(t + 40);

        // 2: all four channels at once from reset -> 0,1,2,3 spaced P+H+1
        do_reset();
        t = cyc;
        req_rx = 4'b1111;
        for (int i = 0; i < 4; i++) push_exp(t + 2 + i * (P + H + 1), 1 << i, P, i, i + 1);
        at_cycle(t + 1);
        req_rx = '0;
        at_cycle(t + 2 + 4 * (P + H + 1) + 5);

        // 3: rx[1] and all[3] together -> only the ALL pulse
        do_reset();
        t = cyc;
        req_rx  = 4'b0010;
        req_all = 4'b1000;
        push_exp(t + 2, 5'b10000, P, 0, 1);
        at_cycle(t + 1);
        req_rx  = '0;
        req_all = '0;
        at_cycle(t + 60);
        check("t3_queue_drained", exp_q.size(), 0);

        // 4: held request gives one pulse; drop/re-raise in HOLDOFF queues the next
        t = cyc;
        req_rx = 4'b0001;
        push_exp(t + 2, 5'b00001, P, 0, 2);
        at_cycle(t + 5000);
        req_rx = '0;
        at_cycle(t + 5002);
        t = cyc;
        req_rx = 4'b0001;
        push_exp(t + 2, 5'b00001, P, 0, 3);
        push_exp(t + 2 + P + H + 1, 5'b00001, P, 0, 4);
        at_cycle(t + 20);
        req_rx = '0;
        at_cycle(t + 22);
        req_rx = 4'b0001;
        at_cycle(t + 23);
        req_rx = '0;
        at_cycle(t + 70);
        check("t4_queue_drained", exp_q.size(), 0);

        // 5: async reset on the fifth pulse cycle with ch3 pending
        do_reset();
        t = cyc;
        req_rx = 4'b1001;
        push_exp(t + 2, 5'b00001, 5, 0, 1);
        at_cycle(t + 1);
        req_rx = '0;
        at_cycle(t + 7);
        rst = 1'b1;
        #1;
        check("t5_rx_out",  int'(rx_out),  0);
        check("t5_all_out", int'(all_out), 0);
        check("t5_busy",    int'(busy),    0);
        check("t5_gcnt",    int'(gcnt),    0);
        at_cycle(t + 10);
        rst = 1'b0;
        at_cycle(t + 90);
        check("t5_busy_idle", int'(busy), 0);
        check("t5_queue_drained", exp_q.size(), 0);

        // 6: 300 sequential grants, count saturates at 255
        do_reset();
        for (int g = 0; g < 300; g++) begin
            t = cyc;
            req_rx = 4'b0001;
            push_exp(t + 2, 5'b00001, P, 0, (g + 1 > 255) ? 255 : g + 1);
            at_cycle(t + 1);
            req_rx = '0;
            at_cycle(t + 28);
        end
        at_cycle(cyc + 40);
        check("t6_gcnt_sat", int'(gcnt), 255);
        check("final_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gtfwizard_mac_reset_sched.md
Name: gtfwizard_mac_reset_sched

Overview:
- Serialises reset requests from P_NUM_CH per-channel GTF initialization controllers, so only one channel reset is in flight at a time.
- Issues an RX datapath reset pulse to the granted channel, or one shared reset-all pulse, then waits a hold-off interval before the next grant.
- Sits in the free-running clock domain, between the per-channel init state machines and the GTF reset controller inputs.

Parameters:
- P_NUM_CH, 4: number of channels; legal range 1..8.
- P_PULSE_CYC, 16: reset pulse width in clk_freerun_in cycles; legal range 1..65535.
- P_HOLDOFF_CYC, 1000: idle gap after each pulse before the next grant; legal range 1..65535.

Ports:
- clk_freerun_in  input  1  free-running clock; all logic is on its rising edge.
- reset_all_in  input  1  asynchronous, active-high reset.
- req_rx_in  input  P_NUM_CH  per-channel RX-reset request; rising-edge sensitive.
- req_all_in  input  P_NUM_CH  per-channel reset-all request; rising-edge sensitive.
- reset_rx_out  output  P_NUM_CH  registered RX reset pulse; one-hot or zero.
- reset_all_out  output  1  registered shared reset-all pulse.
- busy_out  output  1  high while in PULSE or HOLDOFF.
- grant_idx_out  output  3  index of the most recent RX grant.
- grant_cnt_out  output  8  total grants since reset, saturating at 255.

Behaviour:
Reset values (async assert, all registers):
- reset_rx_out=0, reset_all_out=0, busy_out=0, grant_idx_out=0, grant_cnt_out=0.
- Pending bits=0, edge-detect registers=0, state=IDLE, RR pointer=P_NUM_CH-1 (channel 0 has first priority).

Request capture:
- req_*_d registers hold the previous-cycle value; edge = req & ~req_d.
- An edge in cycle t sets pend_rx[i] or pend_all[i] at the t+1 edge.
- A request held high yields exactly one grant. It must drop and rise again to re-request.
- A request high on the first cycle after reset release counts as an edge.
- If an edge arrives on the same cycle its pending bit is cleared by a grant, the set wins and the request stays queued.

State machine:
- IDLE:
  - If any pend_all bit is set, go to PULSE with mode ALL. Clear all pend_all and all pend_rx bits (a reset-all subsumes RX resets).
  - Else if any pend_rx bit is set, pick the first set bit searching from ptr+1 upward with wrap modulo P_NUM_CH. Go to PULSE with mode RX. Clear that bit, set ptr=idx and grant_idx_out=idx.
  - On either grant, increment grant_cnt_out unless it is at 255.
- PULSE:
  - Drive reset_all_out=1 (mode ALL) or reset_rx_out[idx]=1 (mode RX) for exactly P_PULSE_CYC cycles. The first high cycle is the cycle after the IDLE grant decision.
  - Then go to HOLDOFF; outputs drop on that same edge.
- HOLDOFF:
  - Stay exactly P_HOLDOFF_CYC cycles, then go to IDLE.
  - New edges are still captured into pending bits.
- busy_out is registered and equals (state != IDLE).
- One 16-bit down-counter serves both PULSE and HOLDOFF.

Latency:
- A req edge in cycle t with the scheduler idle gives an output pulse from cycle t+2 through t+1+P_PULSE_CYC.
- The earliest following grant produces its pulse P_PULSE_CYC+P_HOLDOFF_CYC+1 cycles after the previous pulse started.

Boundary conditions:
- Simultaneous req_all and req_rx edges: the ALL grant is taken and the rx bit is cleared.
- Simultaneous RX edges on all channels: grants go in round-robin order 0,1,2,3.
- reset_all_in asserted mid-PULSE: outputs clear immediately (async), all pending requests are discarded, and the block resumes in IDLE after release.
- P_NUM_CH=1: the pointer is constant 0 and grant_idx_out is always 0.

Test Plan:
1. Single req_rx_in[2] edge at cycle 10, P_PULSE_CYC=16 → reset_rx_out=4'b0100 exactly in cycles 12..27; busy_out high for 16+P_HOLDOFF_CYC cycles; grant_idx_out=2; grant_cnt_out=1.
2. req_rx_in=4'b1111 edges in the same cycle, P_HOLDOFF_CYC=10 → four pulses on ch0,1,2,3 in order, each starting 27 cycles after the previous; grant_cnt_out=4.
3. req_rx_in[1] and req_all_in[3] edges together → a single reset_all_out pulse of 16 cycles and no reset_rx_out[1] pulse afterwards.
4. req_rx_in[0] held high for 5000 cycles → exactly one pulse; drop and re-raise during HOLDOFF → second pulse starts immediately after HOLDOFF ends.
5. reset_all_in asserted at pulse cycle 5 with ch3 pending → all outputs 0 asynchronously; after release, no pulse without a new edge.
6. 300 sequential grants → grant_cnt_out saturates at 255 and stays there.
